// File: rtl/scpu_pkg.sv
// Shared encodings for the Scpu multi-cycle control path.
// ALU ops, ISA fields, mux selects and controller states.
package scpu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_EQ  = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] BSEL_RT     = 2'b00;
  localparam logic [1:0] BSEL_FOUR   = 2'b01;
  localparam logic [1:0] BSEL_IMM    = 2'b10;
  localparam logic [1:0] BSEL_IMM_SH = 2'b11;

  localparam logic [1:0] PCSEL_ALU = 2'b00;
  localparam logic [1:0] PCSEL_TGT = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_ADDR,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_EXEC_BEQ
  } state_t;

  function automatic logic r_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_OR);
  endfunction

  function automatic logic [2:0] funct_op(input logic [5:0] fn);
    logic [2:0] op;
    op = ALU_ADD;
    if (fn == FN_SUB)
      op = ALU_SUB;
    else if (fn == FN_OR)
      op = ALU_OR;
    return op;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter for the multi-cycle controller.
// Flags a timeout when a request has waited LIMIT cycles.
module mc_wait_timer
  import scpu_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  assign timeout = active && !ready && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (!active || ready || timeout)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Scpu multi-cycle control unit: fetch/decode/execute/mem/wb
// sequencing with instruction register and memory wait timeout.
module mc_ctrl
  import scpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_eq,
  output logic [31:0] ir,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [2:0]  alu_op,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        tgt_we,
  output logic        reg_we,
  output logic        reg_dst_sel,
  output logic        wb_sel,
  output logic        illegal,
  output logic        mem_err
);

  state_t state;
  state_t nxt;
  logic   is_lw;
  logic   ir_ld;
  logic   wait_act;
  logic   tmo;

  logic [5:0] opc;
  logic [5:0] fn;
  logic       dec_r;
  logic       dec_mem;
  logic       dec_beq;
  logic       dec_j;

  assign opc = ir[31:26];
  assign fn  = ir[5:0];

  assign dec_r   = (opc == OP_RTYPE) && r_legal(fn);
  assign dec_mem = (opc == OP_LW) || (opc == OP_SW);
  assign dec_beq = (opc == OP_BEQ);
  assign dec_j   = (opc == OP_J);

  assign wait_act = (state == S_FETCH)
                 || (state == S_MEM_RD)
                 || (state == S_MEM_WR);

  mc_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (wait_act),
    .ready  (mem_ready),
    .timeout(tmo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ir    <= '0;
      is_lw <= 1'b0;
    end else begin
      state <= nxt;
      if (ir_ld)
        ir <= mem_rdata;
      if (state == S_DECODE)
        is_lw <= (opc == OP_LW);
    end
  end

  // All outputs stay low while reset is held.
  always_comb begin
    nxt          = state;
    ir_ld        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = ALU_ADD;
    alu_a_sel    = 1'b0;
    alu_b_sel    = BSEL_RT;
    pc_we        = 1'b0;
    pc_sel       = PCSEL_ALU;
    tgt_we       = 1'b0;
    reg_we       = 1'b0;
    reg_dst_sel  = 1'b0;
    wb_sel       = 1'b0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_b_sel = BSEL_FOUR;
          if (mem_ready) begin
            pc_we = 1'b1;
            ir_ld = 1'b1;
            nxt   = S_DECODE;
          end else if (tmo) begin
            mem_err = 1'b1;
          end
        end
        S_DECODE: begin
          alu_b_sel = BSEL_IMM_SH;
          tgt_we    = 1'b1;
          unique case (1'b1)
            dec_r:   nxt = S_EXEC_R;
            dec_mem: nxt = S_EXEC_ADDR;
            dec_beq: nxt = S_EXEC_BEQ;
            dec_j: begin
              pc_we  = 1'b1;
              pc_sel = PCSEL_JMP;
              nxt    = S_FETCH;
            end
            default: begin
              illegal = 1'b1;
              nxt     = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_op    = funct_op(fn);
          alu_a_sel = 1'b1;
          nxt       = S_WB_R;
        end
        S_WB_R: begin
          alu_op      = funct_op(fn);
          alu_a_sel   = 1'b1;
          reg_we      = 1'b1;
          reg_dst_sel = 1'b1;
          nxt         = S_FETCH;
        end
        S_EXEC_ADDR: begin
          alu_a_sel = 1'b1;
          alu_b_sel = BSEL_IMM;
          nxt       = is_lw ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          if (mem_ready) begin
            nxt = S_WB_LD;
          end else if (tmo) begin
            mem_err = 1'b1;
            nxt     = S_FETCH;
          end
        end
        S_WB_LD: begin
          reg_we = 1'b1;
          wb_sel = 1'b1;
          nxt    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = 1'b1;
          if (mem_ready) begin
            nxt = S_FETCH;
          end else if (tmo) begin
            mem_err = 1'b1;
            nxt     = S_FETCH;
          end
        end
        S_EXEC_BEQ: begin
          alu_op    = ALU_EQ;
          alu_a_sel = 1'b1;
          if (alu_eq) begin
            pc_we  = 1'b1;
            pc_sel = PCSEL_TGT;
          end
          nxt = S_FETCH;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed vector bench for mc_ctrl (WAIT_LIMIT = 4).
// Per-cycle output vectors plus instruction latency checks.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        alu_eq;
  logic [31:0] ir;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [2:0]  alu_op;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        tgt_we;
  logic        reg_we;
  logic        reg_dst_sel;
  logic        wb_sel;
  logic        illegal;
  logic        mem_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl #(
    .WAIT_LIMIT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .alu_eq      (alu_eq),
    .ir          (ir),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .alu_op      (alu_op),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .tgt_we      (tgt_we),
    .reg_we      (reg_we),
    .reg_dst_sel (reg_dst_sel),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  // {req,we,addr_sel,op[2:0],a,b[1:0],pc_we,pc_sel[1:0],tgt,reg_we,dst,wb,ill,err}
  function automatic logic [17:0] mk(
    input bit rq, input bit we, input bit as,
    input bit [2:0] op, input bit a, input bit [1:0] b,
    input bit pw, input bit [1:0] ps, input bit tw,
    input bit rw, input bit rd, input bit wb,
    input bit il, input bit er);
    return {rq, we, as, op, a, b, pw, ps, tw, rw, rd, wb, il, er};
  endfunction

  localparam logic [17:0] O_ZERO = '0;
  localparam logic [17:0] O_FETCH =
    mk(1,0,0,3'b000,0,2'b01,0,2'b00,0,0,0,0,0,0);
  localparam logic [17:0] O_FRDY =
    mk(1,0,0,3'b000,0,2'b01,1,2'b00,0,0,0,0,0,0);
  localparam logic [17:0] O_FERR =
    mk(1,0,0,3'b000,0,2'b01,0,2'b00,0,0,0,0,0,1);
  localparam logic [17:0] O_DEC =
    mk(0,0,0,3'b000,0,2'b11,0,2'b00,1,0,0,0,0,0);
  localparam logic [17:0] O_DJ =
    mk(0,0,0,3'b000,0,2'b11,1,2'b10,1,0,0,0,0,0);
  localparam logic [17:0] O_DILL =
    mk(0,0,0,3'b000,0,2'b11,0,2'b00,1,0,0,0,1,0);
  localparam logic [17:0] O_EXA =
    mk(0,0,0,3'b000,1,2'b10,0,2'b00,0,0,0,0,0,0);
  localparam logic [17:0] O_MRD =
    mk(1,0,1,3'b000,0,2'b00,0,2'b00,0,0,0,0,0,0);
  localparam logic [17:0] O_MRDE =
    mk(1,0,1,3'b000,0,2'b00,0,2'b00,0,0,0,0,0,1);
  localparam logic [17:0] O_WBLD =
    mk(0,0,0,3'b000,0,2'b00,0,2'b00,0,1,0,1,0,0);
  localparam logic [17:0] O_MWR =
    mk(1,1,1,3'b000,0,2'b00,0,2'b00,0,0,0,0,0,0);
  localparam logic [17:0] O_BEQT =
    mk(0,0,0,3'b011,1,2'b00,1,2'b01,0,0,0,0,0,0);
  localparam logic [17:0] O_BEQN =
    mk(0,0,0,3'b011,1,2'b00,0,2'b00,0,0,0,0,0,0);

  function automatic logic [17:0] exr(input bit [2:0] op);
    return mk(0,0,0,op,1,2'b00,0,2'b00,0,0,0,0,0,0);
  endfunction

  function automatic logic [17:0] wbr(input bit [2:0] op);
    return mk(0,0,0,op,1,2'b00,0,2'b00,0,1,1,0,0,0);
  endfunction

  localparam logic [31:0] I_ADD = 32'h012A4020;
  localparam logic [31:0] I_SUB = 32'h012A4022;
  localparam logic [31:0] I_OR  = 32'h012A4025;
  localparam logic [31:0] I_BAD = 32'h012A4021;
  localparam logic [31:0] I_LW  = 32'h8D280004;
  localparam logic [31:0] I_SW  = 32'hAD280004;
  localparam logic [31:0] I_BEQ = 32'h11090003;
  localparam logic [31:0] I_ILL = 32'hFC000000;
  localparam logic [31:0] I_J   = 32'h08000010;

  typedef struct {
    string       name;
    logic        rst;
    logic        rdy;
    logic        eq;
    logic [31:0] rd;
    logic [17:0] exp;
    logic        irc;
    logic [31:0] eir;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] cur_ir = '0;
  logic        ir_known = 1'b0;

  task automatic v(input string nm, input logic rs, input logic rdy,
                   input logic eq, input logic [31:0] rd,
                   input logic [17:0] ex);
    vec_t e;
    e.name = nm; e.rst = rs; e.rdy = rdy; e.eq = eq;
    e.rd = rd; e.exp = ex; e.irc = ir_known; e.eir = cur_ir;
    vq.push_back(e);
    if (!rs) begin
      cur_ir = '0;
      ir_known = 1'b1;
    end else if (ex[17] && !ex[15] && rdy) begin
      cur_ir = rd;
    end
  endtask

  // Idle-input shorthand for non-fetch cycles.
  task automatic s(input string nm, input logic [17:0] ex);
    v(nm, 1'b1, 1'b0, 1'b0, 32'h0, ex);
  endtask

  function automatic logic [17:0] outs();
    return {mem_req, mem_we, mem_addr_sel, alu_op, alu_a_sel,
            alu_b_sel, pc_we, pc_sel, tgt_we, reg_we,
            reg_dst_sel, wb_sel, illegal, mem_err};
  endfunction

  task automatic measure(input string nm, input logic [31:0] ins,
                         input int want);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = ins;
      alu_eq = 1'b0;
      #1;
      n++;
      if (n > 1 && mem_req && !mem_addr_sel) begin
        hit = 1'b1;
        mem_ready = 1'b0;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: no return to fetch within 20 cycles, want %0d",
               nm, want);
    end else if (n - 1 != want) begin
      n_fail++;
      $display("FAIL %s: latency got %0d want %0d", nm, n - 1, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    alu_eq = 1'b0;

    v("rst0", 0, 1, 1, I_ADD, O_ZERO);
    v("rst1", 0, 1, 1, I_ADD, O_ZERO);
    v("add_f", 1, 1, 0, I_ADD, O_FRDY);
    s("add_d", O_DEC);
    s("add_x", exr(3'b000));
    s("add_w", wbr(3'b000));
    v("sub_f", 1, 1, 0, I_SUB, O_FRDY);
    s("sub_d", O_DEC);
    s("sub_x", exr(3'b001));
    s("sub_w", wbr(3'b001));
    v("or_f", 1, 1, 0, I_OR, O_FRDY);
    s("or_d", O_DEC);
    s("or_x", exr(3'b010));
    s("or_w", wbr(3'b010));
    v("lw_f", 1, 1, 0, I_LW, O_FRDY);
    s("lw_d", O_DEC);
    s("lw_a", O_EXA);
    s("lw_m0", O_MRD);
    s("lw_m1", O_MRD);
    s("lw_m2", O_MRD);
    v("lw_m3", 1, 1, 0, 32'h0, O_MRD);
    s("lw_w", O_WBLD);
    v("sw_f", 1, 1, 0, I_SW, O_FRDY);
    s("sw_d", O_DEC);
    s("sw_a", O_EXA);
    v("sw_m", 1, 1, 0, 32'h0, O_MWR);
    v("beq1_f", 1, 1, 1, I_BEQ, O_FRDY);
    v("beq1_d", 1, 0, 1, 32'h0, O_DEC);
    v("beq1_x", 1, 0, 1, 32'h0, O_BEQT);
    v("beq0_f", 1, 1, 0, I_BEQ, O_FRDY);
    s("beq0_d", O_DEC);
    s("beq0_x", O_BEQN);
    v("ill_f", 1, 1, 0, I_ILL, O_FRDY);
    s("ill_d", O_DILL);
    v("fn_f", 1, 1, 0, I_BAD, O_FRDY);
    s("fn_d", O_DILL);
    v("j_f", 1, 1, 0, I_J, O_FRDY);
    s("j_d", O_DJ);
    s("to_0", O_FETCH);
    s("to_1", O_FETCH);
    s("to_2", O_FETCH);
    s("to_3", O_FERR);
    s("to_4", O_FETCH);
    s("to_5", O_FETCH);
    s("to_6", O_FETCH);
    v("lim_sw", 1, 1, 0, I_SW, O_FRDY);
    s("rs_d", O_DEC);
    s("rs_a", O_EXA);
    s("rs_m", O_MWR);
    v("rs_hold", 0, 0, 0, 32'h0, O_ZERO);
    s("rs_f0", O_FETCH);
    s("rs_f1", O_FETCH);
    s("rs_f2", O_FETCH);
    v("rt_f", 1, 1, 0, I_LW, O_FRDY);
    s("rt_d", O_DEC);
    s("rt_a", O_EXA);
    s("rt_m0", O_MRD);
    s("rt_m1", O_MRD);
    s("rt_m2", O_MRD);
    s("rt_m3", O_MRDE);
    s("rt_f", O_FETCH);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst;
      mem_ready = vq[i].rdy;
      alu_eq = vq[i].eq;
      mem_rdata = vq[i].rd;
      #1;
      n_chk++;
      if (outs() !== vq[i].exp) begin
        n_fail++;
        $display("FAIL %s: outputs got %b want %b",
                 vq[i].name, outs(), vq[i].exp);
      end
      if (vq[i].irc) begin
        n_chk++;
        if (ir !== vq[i].eir) begin
          n_fail++;
          $display("FAIL %s: ir got %h want %h",
                   vq[i].name, ir, vq[i].eir);
        end
      end
    end

    measure("lat_j", I_J, 2);
    measure("lat_beq", I_BEQ, 3);
    measure("lat_add", I_ADD, 4);
    measure("lat_sw", I_SW, 4);
    measure("lat_lw", I_LW, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, limit 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
